serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial two's-complement subtractor for the MIPS32 ALU datapath, complementing the ripple adder path. It computes a − b one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop. It trades latency for area and returns the difference with unsigned-borrow, signed-overflow and zero flags under a start/busy/done handshake.

## Interface

- WIDTH, 32, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  minuend; captured on the accepting edge
- b  input  WIDTH  subtrahend; captured on the accepting edge
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when a result is published
- diff  output  WIDTH  a − b modulo 2^WIDTH
- borrow  output  1  1 iff unsigned a < b
- overflow  output  1  signed overflow of a − b
- zero  output  1  1 iff diff == 0

## Operation

- States:
  - IDLE: wait for start.
  - RUN: process one bit per cycle.
  - DONE: result published, done = 1.
- IDLE or DONE with start = 1 at a rising edge:
  - Capture a and b into shift registers.
  - Clear the borrow flip-flop and the bit counter.
  - Go to RUN.
- IDLE with start = 0: stay in IDLE. DONE with start = 0: go to IDLE.
- Each RUN edge processes bit i (i = counter) in the full-subtractor cell:
  - d = a_i ^ b_i ^ br
  - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - Shift d into the result register from the MSB end. Shift the operand registers right. Increment the counter.
- On the RUN edge that processes bit WIDTH−1:
  - Go to DONE.
  - Load diff with the full result and borrow with the final br'.
  - Load overflow = (a[W−1] ≠ b[W−1]) & (diff[W−1] ≠ a[W−1]), using the captured operand values.
  - Load zero = (diff == 0).
- Output registers (diff, borrow, overflow, zero) change only on a completion edge. They hold the last result through IDLE and through the next RUN.
- start during RUN is ignored, with no queuing.
- Changes on a or b after the accepting edge have no effect.
- busy = 1 exactly in RUN. done = 1 exactly in DONE.
- Reset (rst_n low, any time, including mid-RUN):
  - State goes to IDLE immediately, and the operation in flight is discarded.
  - busy, done, diff, borrow, overflow and zero all read 0.
  - No done pulse is produced for the aborted operation.
  - Operation resumes on the first rising edge with rst_n high.

## Timing

- Acceptance at edge k. busy is high from after edge k through edge k+WIDTH.
- Bits 0..WIDTH−1 are processed at edges k+1..k+WIDTH.
- Results and done are valid after edge k+WIDTH. done falls after edge k+WIDTH+1.
- Latency from acceptance to done is WIDTH cycles (32 at default).
- Back-to-back: start high during the DONE cycle is accepted at edge k+WIDTH+1. Throughput is therefore one result per WIDTH+1 cycles.
- There are no combinational paths from inputs to outputs. Every output is a register.

## Test plan

- Reset: hold rst_n low for 3 cycles with random a, b and start. Required: busy = done = diff = borrow = overflow = zero = 0. Release, with start = 0 → all outputs stay 0.
- a = 5, b = 3, start pulse. Required: busy high for 32 cycles, then done is a single pulse 32 edges after acceptance. diff = 2, borrow = 0, overflow = 0, zero = 0.
- Borrow and overflow vectors:
  - a = 3, b = 5 → diff = 0xFFFFFFFE, borrow = 1, overflow = 0.
  - a = 0x80000000, b = 1 → diff = 0x7FFFFFFF, borrow = 0, overflow = 1.
  - a = 0x7FFFFFFF, b = 0xFFFFFFFF → diff = 0x80000000, borrow = 1, overflow = 1.
- a = b = 0x00001234 → diff = 0, zero = 1, borrow = 0.
- Handshake and hold:
  - Toggle start and change a, b during RUN → no effect; the result matches the captured operands.
  - Outputs hold the previous result through a new RUN until its completion edge.
  - start asserted during the DONE cycle → a new RUN begins with no idle cycle.
- Reset mid-operation: drop rst_n asynchronously (between clock edges) on RUN cycle 10. Required:
  - busy falls immediately.
  - No done pulse appears.
  - All outputs read 0.
  - A new start after release completes normally: a = 10, b = 10 → diff = 0, zero = 1.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial two's-complement subtractor. It computes a - b one bit per clock,
// LSB first, using a single full-subtractor cell and a borrow flip-flop. The
// difference is published with unsigned-borrow, signed-overflow and zero flags.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start_i     request; sampled only while not busy (IDLE or DONE)
//   a_i, b_i    minuend / subtrahend, captured on the accepting edge
//   busy_o      high while a subtraction is in progress
//   done_o      one-cycle pulse when a result is published
//   diff_o      a - b modulo 2^WIDTH
//   borrow_o    1 iff unsigned a < b
//   overflow_o  signed overflow of a - b
//   zero_o      1 iff diff == 0
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int CW = $clog2(WIDTH);

  // Encoding chosen so busy and done are single state flop bits, keeping every
  // output a pure register.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aShift_q, bShift_q;
  logic [WIDTH-2:0] partial_q;
  logic [WIDTH-1:0] result_d;
  logic [CW-1:0]    count_q;
  logic             borrowBit_q, borrowBit_d;
  logic             diffBit;
  logic             accept, lastBit;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, overflow_q, zero_q;

  assign accept  = start_i && (state_q != RUN);
  assign lastBit = (count_q == CW'(WIDTH - 1));

  // Full-subtractor cell working on the LSBs of the operand shift registers.
  // The partial result fills from the MSB end; on the last bit the new
  // difference bit lands in the MSB and the earlier bits are already in place.
  always_comb begin
    diffBit     = aShift_q[0] ^ bShift_q[0] ^ borrowBit_q;
    borrowBit_d = (~aShift_q[0] & bShift_q[0]) |
                  (~(aShift_q[0] ^ bShift_q[0]) & borrowBit_q);
    result_d    = {diffBit, partial_q};
  end

  // Next-state logic. Start is honoured from IDLE and DONE only, so a request
  // during RUN is simply dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (lastBit) state_d = DONE;
      DONE:    state_d = start_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath. Output flags are only written on the completion edge, so they
  // hold the previous result through IDLE and through the next RUN. By the
  // last bit the operand registers have shifted the sign bits down to bit 0,
  // which is why overflow reads the captured signs from there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aShift_q    <= '0;
      bShift_q    <= '0;
      partial_q   <= '0;
      count_q     <= '0;
      borrowBit_q <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else if (accept) begin
      aShift_q    <= a_i;
      bShift_q    <= b_i;
      count_q     <= '0;
      borrowBit_q <= 1'b0;
    end else if (state_q == RUN) begin
      aShift_q    <= aShift_q >> 1;
      bShift_q    <= bShift_q >> 1;
      partial_q   <= result_d[WIDTH-1:1];
      count_q     <= count_q + CW'(1);
      borrowBit_q <= borrowBit_d;
      if (lastBit) begin
        diff_q     <= result_d;
        borrow_q   <= borrowBit_d;
        overflow_q <= (aShift_q[0] != bShift_q[0]) && (diffBit != aShift_q[0]);
        zero_q     <= (result_d == '0);
      end
    end
  end

  assign busy_o     = state_q[0];
  assign done_o     = state_q[1];
  assign diff_o     = diff_q;
  assign borrow_o   = borrow_q;
  assign overflow_o = overflow_q;
  assign zero_o     = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
// Directed testbench for serial_subtractor (WIDTH = 32). Each scenario task
// drives its own stimulus and compares outputs against hand-computed values.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, borrow, overflow, zero;
  logic [31:0] diff;

  int nChecks = 0;
  int nFails  = 0;

  serial_subtractor #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .diff_o(diff), .borrow_o(borrow),
    .overflow_o(overflow), .zero_o(zero)
  );

  // 10 ns clock; all sampling happens around the falling edge.
  always #5 clk = ~clk;

  // Present operands with start at a falling edge, let the next rising edge
  // accept them, then drop start at the following falling edge.
  task automatic launch(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // From a falling edge, count rising edges until done is seen (bounded).
  task automatic waitDone(output int lat, output int busyCycles);
    lat = 0;
    busyCycles = 0;
    while (!done && lat < 40) begin
      if (busy) busyCycles++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Reset with random inputs, then release with start low.
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      a = $urandom; b = $urandom; start = 1'($urandom_range(0, 1));
      @(negedge clk);
      nChecks++;
      if ({busy, done, diff, borrow, overflow, zero} !== 37'd0) begin
        nFails++;
        $display("[TB] FAIL reset_hold: got busy=%b done=%b diff=%h br=%b ov=%b z=%b required all 0", busy, done, diff, borrow, overflow, zero);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      nChecks++;
      if ({busy, done, diff, borrow, overflow, zero} !== 37'd0) begin
        nFails++;
        $display("[TB] FAIL reset_release: got busy=%b done=%b diff=%h required all 0", busy, done, diff);
      end
    end
  endtask

  // 5 - 3 with busy length, done latency and single-pulse checks.
  task automatic test_basic();
    int lat, bc;
    launch(32'd5, 32'd3);
    waitDone(lat, bc);
    nChecks++; if (lat !== 32) begin nFails++; $display("[TB] FAIL basic_latency: got %0d required 32", lat); end
    nChecks++; if (bc !== 32) begin nFails++; $display("[TB] FAIL basic_busy_len: got %0d required 32", bc); end
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL basic_busy_in_done: got %b required 0", busy); end
    nChecks++; if (diff !== 32'd2) begin nFails++; $display("[TB] FAIL basic_diff: got %h required 00000002", diff); end
    nChecks++; if ({borrow, overflow, zero} !== 3'b000) begin nFails++; $display("[TB] FAIL basic_flags: got %b required 000", {borrow, overflow, zero}); end
    @(negedge clk);
    nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL basic_done_pulse: got %b required 0", done); end
  endtask

  // Borrow and overflow corner vectors.
  task automatic test_flags();
    logic [31:0] va [3] = '{32'd3, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] vb [3] = '{32'd5, 32'd1,         32'hFFFF_FFFF};
    logic [31:0] vd [3] = '{32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000};
    logic        vbr[3] = '{1'b1, 1'b0, 1'b1};
    logic        vov[3] = '{1'b0, 1'b1, 1'b1};
    int lat, bc;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i]);
      waitDone(lat, bc);
      nChecks++; if (lat !== 32) begin nFails++; $display("[TB] FAIL flags_latency[%0d]: got %0d required 32", i, lat); end
      nChecks++; if (diff !== vd[i]) begin nFails++; $display("[TB] FAIL flags_diff[%0d]: got %h required %h", i, diff, vd[i]); end
      nChecks++; if (borrow !== vbr[i]) begin nFails++; $display("[TB] FAIL flags_borrow[%0d]: got %b required %b", i, borrow, vbr[i]); end
      nChecks++; if (overflow !== vov[i]) begin nFails++; $display("[TB] FAIL flags_overflow[%0d]: got %b required %b", i, overflow, vov[i]); end
      nChecks++; if (zero !== 1'b0) begin nFails++; $display("[TB] FAIL flags_zero[%0d]: got %b required 0", i, zero); end
    end
  endtask

  // Equal operands give a zero difference.
  task automatic test_zero();
    int lat, bc;
    launch(32'h0000_1234, 32'h0000_1234);
    waitDone(lat, bc);
    nChecks++; if (diff !== 32'd0) begin nFails++; $display("[TB] FAIL zero_diff: got %h required 00000000", diff); end
    nChecks++; if ({zero, borrow, overflow} !== 3'b100) begin nFails++; $display("[TB] FAIL zero_flags: got z/br/ov=%b required 100", {zero, borrow, overflow}); end
  endtask

  // Start and operand changes during RUN are ignored; outputs hold meanwhile.
  task automatic test_handshake();
    int lat, bc;
    launch(32'd20, 32'd7);
    waitDone(lat, bc);
    nChecks++; if (diff !== 32'd13) begin nFails++; $display("[TB] FAIL hs_first_diff: got %h required 0000000d", diff); end
    @(negedge clk);
    a = 32'h0000_0100; b = 32'd1; start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      start = (i < 20) ? 1'(i % 2) : 1'b0;
      a = $urandom; b = $urandom;
      if (i == 5) begin
        nChecks++; if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL hs_busy: got %b required 1", busy); end
        nChecks++; if (diff !== 32'd13) begin nFails++; $display("[TB] FAIL hs_hold: got %h required 0000000d", diff); end
      end
    end
    waitDone(lat, bc);
    nChecks++; if (lat !== 2) begin nFails++; $display("[TB] FAIL hs_latency: got %0d more edges required 2", lat); end
    nChecks++; if (diff !== 32'h0000_00FF) begin nFails++; $display("[TB] FAIL hs_diff: got %h required 000000ff", diff); end
  endtask

  // Start held during DONE starts the next run with no idle cycle.
  task automatic test_back_to_back();
    int lat, bc;
    launch(32'd9, 32'd4);
    waitDone(lat, bc);
    nChecks++; if (diff !== 32'd5) begin nFails++; $display("[TB] FAIL b2b_first_diff: got %h required 00000005", diff); end
    a = 32'd100; b = 32'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nChecks++; if ({busy, done} !== 2'b10) begin nFails++; $display("[TB] FAIL b2b_no_idle: got busy/done=%b required 10", {busy, done}); end
    nChecks++; if (diff !== 32'd5) begin nFails++; $display("[TB] FAIL b2b_hold: got %h required 00000005", diff); end
    waitDone(lat, bc);
    nChecks++; if (lat !== 32) begin nFails++; $display("[TB] FAIL b2b_latency: got %0d required 32", lat); end
    nChecks++; if (diff !== 32'd99) begin nFails++; $display("[TB] FAIL b2b_diff: got %h required 00000063", diff); end
  endtask

  // Asynchronous reset on RUN cycle 10 aborts the operation.
  task automatic test_reset_mid_run();
    int lat, bc;
    launch(32'h0000_ABCD, 32'd1);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    nChecks++; if ({busy, done, diff, borrow, overflow, zero} !== 37'd0) begin nFails++; $display("[TB] FAIL midrst_clear: got busy=%b done=%b diff=%h required all 0", busy, done, diff); end
    repeat (3) begin
      @(negedge clk);
      nChecks++; if ({busy, done} !== 2'b00) begin nFails++; $display("[TB] FAIL midrst_no_done: got busy/done=%b required 00", {busy, done}); end
    end
    rst_n = 1'b1;
    launch(32'd10, 32'd10);
    waitDone(lat, bc);
    nChecks++; if (lat !== 32) begin nFails++; $display("[TB] FAIL midrst_latency: got %0d required 32", lat); end
    nChecks++; if ({diff, zero} !== {32'd0, 1'b1}) begin nFails++; $display("[TB] FAIL midrst_result: got diff=%h zero=%b required 00000000/1", diff, zero); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_zero();
    test_handshake();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
